// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetcher feeding IF/ID: issues word fetches, buffers {pc, instr} in a FIFO.
// Optional FETCH_PERF_EN adds saturating stall/flush performance counters.
module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] perf_stall_cnt,
  output logic [15:0] perf_flush_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = AW + 2;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_fifo_pc    [DEPTH];
  logic [31:0]   r_fifo_instr [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic          r_inflight;
  logic [31:0]   r_inflight_pc;
  logic          r_squash;

  logic [CW-1:0] w_occ;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;

  // Credits cover both buffered entries and the response still in flight.
  assign w_occ     = CW'(r_count) + CW'(r_inflight);
  assign imem_req  = !rst && !redirect_en && (w_occ < CW'(DEPTH));
  assign imem_addr = r_fetch_pc;
  assign w_issue   = imem_req && imem_gnt;

  assign w_valid   = !rst && (r_count != '0);
  assign w_push    = !rst && !redirect_en && imem_rvalid && r_inflight && !r_squash;
  assign w_pop     = !redirect_en && w_valid && !id_stall;

  assign if_valid  = w_valid;
  assign if_instr  = w_valid ? r_fifo_instr[r_rd_ptr] : '0;
  assign if_pc     = w_valid ? r_fifo_pc[r_rd_ptr]    : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_squash      <= 1'b0;
    end else if (redirect_en) begin
      r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= 1'b0;
      r_squash   <= r_inflight | w_issue;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + 32'd4;
      end
      // Squash only ever guards the single response following a redirect.
      r_squash <= 1'b0;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + PW'(1);
      else if (!w_push && w_pop) r_count <= r_count - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
      r_fifo_instr[r_wr_ptr] <= imem_rdata;
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] r_perf_stall;
  logic [15:0] r_perf_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_valid && id_stall && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 16'd1;
      if (redirect_en && (r_perf_flush != '1))         r_perf_flush <= r_perf_flush + 16'd1;
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Scoreboard bench for fetch_prefetch_queue: granted fetches queue expected {pc, instr}; a monitor checks decode output.
module tb_fetch_prefetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        inject;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_stall_cnt;
  logic [15:0] perf_flush_cnt;
  logic [15:0] m_stall = '0;
  logic [15:0] m_flush = '0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int ncyc  = 0;

  logic [63:0] exp_q[$];
  logic [31:0] model_pc   = RPC;
  bit          last_grant = 1'b0;
  int          first_g    = -1;
  bit          lat_done   = 1'b0;

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .id_stall    (id_stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h expected %h", nm, ncyc, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Memory: answers exactly one cycle after a grant; inject adds a stray rvalid.
  initial begin
    bit          p;
    bit          inj;
    logic [31:0] pa;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      p   = imem_req && imem_gnt;
      pa  = imem_addr;
      inj = inject;
      @(posedge clk);
      #1;
      imem_rvalid = p || inj;
      imem_rdata  = p ? (pa ^ KEY) : 32'hDEAD_BEEF;
    end
  end

  // Monitor and reference model: occupancy is the number of granted, unconsumed, unflushed fetches.
  always @(negedge clk) begin
    int   qs;
    logic er;
    logic ev;
    bit   g;
    ncyc++;
    qs = exp_q.size();
    er = !rst && !redirect_en && (qs < DEPTH);
    ev = !rst && (qs > (last_grant ? 1 : 0));
    chk("imem_req", {31'b0, imem_req}, {31'b0, er});
    if (er && imem_req) chk("imem_addr", imem_addr, model_pc);
    chk("if_valid", {31'b0, if_valid}, {31'b0, ev});
    if (ev && if_valid) begin
      chk("if_pc", if_pc, exp_q[0][63:32]);
      chk("if_instr", if_instr, exp_q[0][31:0]);
    end else if (!if_valid) begin
      chk("if_pc_idle", if_pc, 32'h0);
      chk("if_instr_idle", if_instr, 32'h0);
    end
    if (imem_rvalid && last_grant && !rst && !redirect_en && (qs - 1 > DEPTH - 1)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL fifo_overflow @cycle %0d: occupancy %0d limit %0d", ncyc, qs - 1, DEPTH);
    end
`ifdef FETCH_PERF_EN
    chk("perf_stall_cnt", {16'b0, perf_stall_cnt}, {16'b0, m_stall});
    chk("perf_flush_cnt", {16'b0, perf_flush_cnt}, {16'b0, m_flush});
`endif
    g = er && imem_gnt;
    if (!rst && !lat_done) begin
      if (first_g >= 0 && if_valid) begin
        chk("first_latency", ncyc - first_g, 2);
        lat_done = 1'b1;
      end
      if (first_g < 0 && g) first_g = ncyc;
    end
    if (rst) begin
      exp_q.delete();
      model_pc   = RPC;
      last_grant = 1'b0;
`ifdef FETCH_PERF_EN
      m_stall = '0;
      m_flush = '0;
`endif
    end else begin
`ifdef FETCH_PERF_EN
      if (ev && id_stall && m_stall != 16'hFFFF) m_stall++;
      if (redirect_en && m_flush != 16'hFFFF)    m_flush++;
`endif
      if (redirect_en) begin
        exp_q.delete();
        model_pc   = redirect_pc & 32'hFFFF_FFFC;
        last_grant = 1'b0;
      end else begin
        if (ev && !id_stall) void'(exp_q.pop_front());
        if (g) begin
          exp_q.push_back({model_pc, model_pc ^ KEY});
          model_pc = model_pc + 32'd4;
        end
        last_grant = g;
      end
    end
  end

  initial begin
    rst = 1'b1; imem_gnt = 1'b1; id_stall = 1'b0;
    redirect_en = 1'b0; redirect_pc = '0; inject = 1'b0;
    step(2);
    inject = 1'b1;
    step(1);
    rst = 1'b0; inject = 1'b0;
    step(12);
    id_stall = 1'b1; step(6);
    id_stall = 1'b0; step(8);
    redirect_en = 1'b1; redirect_pc = 32'h0000_0103; step(1);
    redirect_en = 1'b0; step(8);
    repeat (3) begin
      imem_gnt = 1'b1; step(1);
      imem_gnt = 1'b0; step(2);
      imem_gnt = 1'b1; step(1);
    end
    step(6);
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFF8; step(1);
    redirect_en = 1'b0; step(8);
    id_stall = 1'b1; step(5);
    id_stall = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h40; step(1);
    redirect_pc = 32'h80; step(1);
    redirect_en = 1'b0; step(6);
    repeat (3000) begin
      imem_gnt    = ($urandom_range(0, 9) < 7);
      id_stall    = ($urandom_range(0, 9) < 3);
      redirect_en = ($urandom_range(0, 29) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      rst         = ($urandom_range(0, 199) == 0);
      inject      = ($urandom_range(0, 19) == 0);
      step(1);
    end
    rst = 1'b0; redirect_en = 1'b0; id_stall = 1'b0; imem_gnt = 1'b0; inject = 1'b0;
    step(12);
    chk("drain_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Issues sequential word fetches to instruction memory and buffers the returned {pc, instr} pairs in a small FIFO.
- Presents the FIFO head to decode, holding it while decode stalls (load-use hazard).
- Supports a one-cycle redirect that flushes the FIFO and restarts fetch at a new PC.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  byte address of the request; word aligned.
- imem_gnt  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  read data valid; always exactly 1 cycle after the accepting cycle.
- imem_rdata  input  32  instruction word.
- if_valid  output  1  head entry valid.
- if_instr  output  32  head instruction; 32'h0 when !if_valid.
- if_pc  output  32  head PC; 32'h0 when !if_valid.
- id_stall  input  1  decode cannot accept; head is held.
- redirect_en  input  1  flush and restart fetch.
- redirect_pc  input  32  restart address; bits [1:0] ignored and treated as 0.

Behaviour:
- State:
  - fetch_pc[31:0]
  - FIFO of DEPTH × {pc, instr}, with rd/wr pointers and count[log2(DEPTH):0]
  - inflight (1 bit), inflight_pc
  - squash (1 bit)
- Reset (rst=1 at posedge):
  - fetch_pc=RESET_PC, count=0, pointers=0, inflight=0, squash=0.
  - While rst=1, imem_req=0 (combinationally gated). Outputs read if_valid=0, if_instr=0, if_pc=0.
- Request (combinational):
  - imem_req = !rst && !redirect_en && (count + inflight < DEPTH).
  - imem_addr = fetch_pc.
- Issue (imem_req && imem_gnt):
  - inflight<=1, inflight_pc<=fetch_pc.
  - fetch_pc<=fetch_pc+4, modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0.
  - Back-to-back issue is allowed; if no issue this cycle, inflight<=0 after the response.
- Response (imem_rvalid):
  - If inflight && !squash, push {inflight_pc, imem_rdata}.
  - If !inflight or squash, the data is dropped. squash clears on the same edge.
  - The credit check above makes a push into a full FIFO impossible. A bench assertion flags it if it ever occurs.
- Output:
  - if_valid = (count!=0).
  - if_instr/if_pc come combinationally from the entry at rd pointer.
  - Pop when if_valid && !id_stall.
  - While id_stall=1, the head stays stable across cycles.
- Simultaneous push and pop: count unchanged, both pointers advance. Pop on an empty FIFO is a no-op.
- Redirect (redirect_en=1 at posedge), highest priority over issue, push and pop:
  - count<=0, pointers<=0.
  - fetch_pc<={redirect_pc[31:2],2'b00}.
  - squash<=inflight_or_issuing, so the response arriving next cycle is discarded.
  - if_valid=0 on the cycle after the redirect.
  - First new request is on the cycle after the redirect; first new if_valid is no earlier than 2 cycles after that request is granted.
- Latency, empty FIFO, imem_gnt=1 throughout: request accepted at cycle t, if_valid=1 at t+2 (data registered into the FIFO at the t+1 edge).
- Steady-state throughput with !id_stall and imem_gnt=1: 1 instruction/cycle.
- Reset asserted mid-operation overrides everything, including redirect. A response arriving in the cycle after reset deassertion is dropped because inflight=0.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds output perf_stall_cnt[15:0] and output perf_flush_cnt[15:0].
  - perf_stall_cnt increments each cycle with if_valid && id_stall.
  - perf_flush_cnt increments on each redirect_en.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Not defined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset release, memory returns rdata=addr^32'hA5A5_0000, imem_gnt=1, id_stall=0 -> if_pc sequence 0,4,8,C… one per cycle; first if_valid 2 cycles after first grant; if_instr matches.
- id_stall=1 for 6 cycles with DEPTH=4 -> FIFO fills to 4, then imem_req=0; head pc=0x8 held stable all 6 cycles. Release -> 0x8,0xC,0x10,0x14 drain back-to-back with no loss or duplication.
- redirect_en with redirect_pc=0x103 while a request for 0x10 is in flight -> response for 0x10 dropped; next if_pc=0x100, then 0x104; if_valid=0 the cycle after the redirect.
- imem_gnt toggled 1,0,0,1 -> fetch_pc advances only on granted cycles; if_pc stream contiguous, no gaps.
- RESET_PC=32'hFFFF_FFF8 -> if_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- FETCH_PERF_EN defined: 5 stalled-valid cycles and 2 redirects -> perf_stall_cnt=5, perf_flush_cnt=2; rst -> both 0.
